// File: rtl/ifu_if.sv
// Fetch-unit bus: instruction-memory handshake plus the decode-side handshake.
// master is the fetch unit; slave is the memory/decode environment.
interface ifu_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_4;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] npc;
    logic        adel;
    logic [31:0] retired;

    modport master (
        output imem_req, imem_addr, instr, pc, pc_4,
        output instr_valid, adel, retired,
        input  imem_ack, imem_rdata, instr_ready, npc
    );

    modport slave (
        input  imem_req, imem_addr, instr, pc, pc_4,
        input  instr_valid, adel, retired,
        output imem_ack, imem_rdata, instr_ready, npc
    );
endinterface

// File: rtl/ifu.sv
// Instruction fetch unit: owns the PC, fetches words over req/ack and
// hands them to decode; a misaligned next PC parks the unit in ERR.
module ifu #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input logic   clk,
    input logic   reset,
    ifu_if.master bus
);
    typedef enum logic [1:0] {IDLE, FETCH, HOLD, ERR} state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic [31:0] instr, instr_n;
    logic [31:0] retired, retired_n;
    logic        req, req_n;
    logic        valid, valid_n;
    logic        adel, adel_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            pc      <= RESET_PC;
            instr   <= '0;
            retired <= '0;
            req     <= 1'b0;
            valid   <= 1'b0;
            adel    <= 1'b0;
        end else begin
            state   <= state_n;
            pc      <= pc_n;
            instr   <= instr_n;
            retired <= retired_n;
            req     <= req_n;
            valid   <= valid_n;
            adel    <= adel_n;
        end
    end

    always_comb begin
        state_n   = state;
        pc_n      = pc;
        instr_n   = instr;
        retired_n = retired;
        req_n     = req;
        valid_n   = valid;
        adel_n    = adel;
        unique case (state)
            IDLE: begin
                state_n = FETCH;
                req_n   = 1'b1;
            end
            FETCH: begin
                if (bus.imem_ack) begin
                    instr_n = bus.imem_rdata;
                    valid_n = 1'b1;
                    req_n   = 1'b0;
                    state_n = HOLD;
                end
            end
            HOLD: begin
                if (bus.instr_ready) begin
                    pc_n      = bus.npc;
                    valid_n   = 1'b0;
                    retired_n = retired + 32'd1;
                    // Only word-aligned targets may be fetched.
                    if (bus.npc[1:0] == 2'b00) begin
                        state_n = FETCH;
                        req_n   = 1'b1;
                    end else begin
                        state_n = ERR;
                        adel_n  = 1'b1;
                        req_n   = 1'b0;
                    end
                end
            end
            ERR: begin
                state_n = ERR;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign bus.imem_req    = req;
    assign bus.imem_addr   = pc;
    assign bus.instr       = instr;
    assign bus.pc          = pc;
    assign bus.pc_4        = pc + 32'd4;
    assign bus.instr_valid = valid;
    assign bus.adel        = adel;
    assign bus.retired     = retired;
endmodule

// File: tb/tb_ifu.sv
// Bench for ifu: scripted memory/decode driver with a fetch scoreboard
// holding the pc/instr pair expected at each decode handshake.
module tb_ifu;
    logic clk;
    logic reset;

    ifu_if bus ();

    ifu dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } sb_t;

    sb_t         sb[$];
    int          total;
    int          bad;
    logic [31:0] exp_pc;
    logic [31:0] exp_ret;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_reset_state();
        chk("rst_req", {31'b0, bus.imem_req}, 32'd0);
        chk("rst_valid", {31'b0, bus.instr_valid}, 32'd0);
        chk("rst_adel", {31'b0, bus.adel}, 32'd0);
        chk("rst_retired", bus.retired, 32'd0);
        chk("rst_instr", bus.instr, 32'd0);
        chk("rst_pc", bus.pc, 32'h3000);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        bus.imem_ack = 1'b0;
        bus.imem_rdata = '0;
        bus.instr_ready = 1'b0;
        bus.npc = '0;
        repeat (2) @(negedge clk);
        chk_reset_state();
        exp_pc = 32'h3000;
        exp_ret = '0;
        sb.delete();
        reset = 1'b1;
        @(negedge clk);
        chk("first_req", {31'b0, bus.imem_req}, 32'd1);
    endtask

    task automatic fetch_one(input int wait_n, input int stall_n,
                             input logic [31:0] nxt);
        logic [31:0] data;
        sb_t e;
        int k;
        k = 0;
        while (!bus.imem_req && k < 8) begin
            @(negedge clk);
            k++;
        end
        if (!bus.imem_req) begin
            chk("req_timeout", 32'd0, 32'd1);
            return;
        end
        chk("addr", bus.imem_addr, exp_pc);
        for (int i = 0; i < wait_n; i++) begin
            chk("req_wait", {31'b0, bus.imem_req}, 32'd1);
            chk("addr_hold", bus.imem_addr, exp_pc);
            chk("valid_wait", {31'b0, bus.instr_valid}, 32'd0);
            @(negedge clk);
        end
        data = $urandom;
        bus.imem_ack = 1'b1;
        bus.imem_rdata = data;
        sb.push_back('{exp_pc, data});
        @(negedge clk);
        bus.imem_ack = 1'b0;
        bus.imem_rdata = $urandom;
        chk("valid_rise", {31'b0, bus.instr_valid}, 32'd1);
        chk("req_drop", {31'b0, bus.imem_req}, 32'd0);
        chk("pc_4", bus.pc_4, exp_pc + 32'd4);
        for (int i = 0; i < stall_n; i++) begin
            bus.npc = $urandom;
            @(negedge clk);
            chk("stall_valid", {31'b0, bus.instr_valid}, 32'd1);
            chk("stall_pc", bus.pc, exp_pc);
            chk("stall_instr", bus.instr, data);
        end
        bus.instr_ready = 1'b1;
        bus.npc = nxt;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk("sb_pc", bus.pc, e.pc);
            chk("sb_instr", bus.instr, e.instr);
        end
        @(negedge clk);
        bus.instr_ready = 1'b0;
        bus.npc = $urandom;
        exp_pc = nxt;
        exp_ret = exp_ret + 32'd1;
        chk("retired", bus.retired, exp_ret);
        chk("pc_load", bus.pc, exp_pc);
        chk("valid_drop", {31'b0, bus.instr_valid}, 32'd0);
        if (nxt[1:0] == 2'b00) begin
            chk("req_rearm", {31'b0, bus.imem_req}, 32'd1);
            chk("adel_clr", {31'b0, bus.adel}, 32'd0);
        end else begin
            chk("req_err", {31'b0, bus.imem_req}, 32'd0);
            chk("adel_set", {31'b0, bus.adel}, 32'd1);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        do_reset();

        fetch_one(0, 0, 32'h3004);
        fetch_one(0, 0, 32'h3008);
        fetch_one(0, 0, 32'h300C);
        chk("retired_3", bus.retired, 32'd3);

        fetch_one(3, 0, 32'h3010);
        fetch_one(0, 4, 32'h3400);
        fetch_one(1, 2, 32'h3002);

        for (int i = 0; i < 10; i++) begin
            bus.imem_ack = i[0];
            bus.instr_ready = ~i[0];
            bus.npc = $urandom;
            bus.imem_rdata = $urandom;
            @(negedge clk);
            chk("err_adel", {31'b0, bus.adel}, 32'd1);
            chk("err_req", {31'b0, bus.imem_req}, 32'd0);
            chk("err_valid", {31'b0, bus.instr_valid}, 32'd0);
            chk("err_pc", bus.pc, 32'h3002);
            chk("err_retired", bus.retired, exp_ret);
        end
        bus.imem_ack = 1'b0;
        bus.instr_ready = 1'b0;

        do_reset();
        fetch_one(0, 0, 32'h3004);

        // Pull reset low between edges while a fetch is outstanding.
        #2;
        reset = 1'b0;
        #1;
        chk("async_req", {31'b0, bus.imem_req}, 32'd0);
        chk("async_valid", {31'b0, bus.instr_valid}, 32'd0);
        bus.imem_ack = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        chk("async_ack_req", {31'b0, bus.imem_req}, 32'd0);
        chk("async_ack_valid", {31'b0, bus.instr_valid}, 32'd0);
        chk("async_ack_instr", bus.instr, 32'd0);
        chk("async_pc", bus.pc, 32'h3000);
        @(negedge clk);
        bus.imem_ack = 1'b0;
        exp_pc = 32'h3000;
        exp_ret = '0;
        sb.delete();
        reset = 1'b1;
        @(negedge clk);
        chk("restart_req", {31'b0, bus.imem_req}, 32'd1);

        fetch_one(0, 0, 32'hFFFF_FFFC);
        chk("wrap_pc_4", bus.pc_4, 32'd0);
        fetch_one(0, 0, 32'h0000_0000);
        fetch_one(0, 0, 32'h0000_0004);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
